// File: rtl/lib_cpu.sv
// Shared CPU field types: opcode/funct widths, instruction format selector,
// fixed opcode values and the encoder FSM state type.
package lib_cpu;

  typedef logic [5:0] OPECODE;
  typedef logic [5:0] FUNCT;

  typedef enum logic [1:0] {
    FMT_R       = 2'd0,
    FMT_I       = 2'd1,
    FMT_J       = 2'd2,
    FMT_ILLEGAL = 2'd3
  } INSN_FMT;

  localparam OPECODE OP_RTYPE = 6'd0;
  localparam OPECODE OP_J     = 6'd2;
  localparam OPECODE OP_JAL   = 6'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/insn_pack.sv
// Combinational packer: instruction fields in, 32-bit word and legality out.
module insn_pack
  import lib_cpu::*;
(
  input  INSN_FMT      fmt,
  input  OPECODE       op,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic [4:0]   shamt,
  input  FUNCT         funct,
  input  logic [15:0]  imm,
  input  logic [25:0]  target,
  output logic [31:0]  word,
  output logic         legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {6'b0, rs, rt, rd, shamt, funct};
        legal = (op == OP_RTYPE);
      end
      FMT_I: begin
        word  = {op, rs, rt, imm};
        legal = (op != OP_RTYPE) && (op != OP_J) && (op != OP_JAL);
      end
      FMT_J: begin
        word  = {op, target};
        legal = (op == OP_J) || (op == OP_JAL);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes a burst of fields into words and writes
// them to consecutive word addresses, rejecting and counting illegal fields.
module instr_encoder
  import lib_cpu::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  INSN_FMT           fmt,
  input  OPECODE            op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  FUNCT              funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  enc_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       word;
  logic              legal;

  insn_pack u_pack (
    .fmt    (fmt),
    .op     (op),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm    (imm),
    .target (target),
    .word   (word),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err       <= 1'b0;
            err_cnt   <= '0;
            addr      <= base_addr & ~ADDR_W'(3);
            remaining <= count;
            if (count != '0) begin
              state    <= ST_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_valid && in_ready) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= word;
              addr       <= addr + ADDR_W'(4);
              remaining  <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end
            end else begin
              // Illegal words are swallowed; only the error bookkeeping moves.
              err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised bench for instr_encoder with a behavioural burst model.
module tb_instr_encoder;
  import lib_cpu::*;

  typedef struct {
    INSN_FMT     fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } w_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic in_valid = 1'b0;
  INSN_FMT fmt = FMT_R;
  logic [5:0] op = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0] err_cnt;

  instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  w_t pend[$];
  logic [63:0] wlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic w_t mk(INSN_FMT f, logic [5:0] o, logic [4:0] s, logic [4:0] t,
                            logic [4:0] d, logic [5:0] fn, logic [15:0] im, logic [25:0] tg);
    w_t w;
    w.fmt = f; w.op = o; w.rs = s; w.rt = t; w.rd = d; w.shamt = 5'd0;
    w.funct = fn; w.imm = im; w.target = tg;
    return w;
  endfunction

  function automatic w_t rnd_word();
    w_t w;
    int k = int'($urandom_range(9));
    w.fmt = (k < 3) ? FMT_R : (k < 6) ? FMT_I : (k < 9) ? FMT_J : FMT_ILLEGAL;
    w.rs = 5'($urandom); w.rt = 5'($urandom); w.rd = 5'($urandom);
    w.shamt = 5'($urandom); w.funct = 6'($urandom);
    w.imm = 16'($urandom); w.target = 26'($urandom);
    if ($urandom_range(99) < 80) begin
      case (w.fmt)
        FMT_R:   w.op = 6'd0;
        FMT_I:   w.op = 6'(8 + $urandom_range(50));
        default: w.op = 6'(2 + $urandom_range(1));
      endcase
    end else begin
      w.op = 6'($urandom);
    end
    return w;
  endfunction

  // Reference encoding and legality from the format rules, by arithmetic.
  task automatic ref_word(input w_t w, output bit ok, output logic [31:0] d);
    ok = 1'b0;
    d  = '0;
    case (w.fmt)
      FMT_R: begin
        ok = (w.op == 6'd0);
        d  = 32'(w.rs) * 32'h20_0000 + 32'(w.rt) * 32'h1_0000 + 32'(w.rd) * 32'h800
           + 32'(w.shamt) * 32'd64 + 32'(w.funct);
      end
      FMT_I: begin
        ok = !(w.op inside {6'd0, 6'd2, 6'd3});
        d  = 32'(w.op) * 32'h400_0000 + 32'(w.rs) * 32'h20_0000
           + 32'(w.rt) * 32'h1_0000 + 32'(w.imm);
      end
      FMT_J: begin
        ok = (w.op == 6'd2) || (w.op == 6'd3);
        d  = 32'(w.op) * 32'h400_0000 + 32'(w.target);
      end
      default: ok = 1'b0;
    endcase
  endtask

  function automatic w_t cur_word();
    w_t w;
    w.fmt = fmt; w.op = op; w.rs = rs; w.rt = rt; w.rd = rd; w.shamt = shamt;
    w.funct = funct; w.imm = imm; w.target = target;
    return w;
  endfunction

  task automatic drive_word(input w_t w);
    fmt = w.fmt; op = w.op; rs = w.rs; rt = w.rt; rd = w.rd; shamt = w.shamt;
    funct = w.funct; imm = w.imm; target = w.target;
  endtask

  // Behavioural model: phase 0 idle, 1 accepting words, 2 finished.
  int m_phase = 0, m_rem = 0, m_cnt = 0;
  bit m_err = 0, m_ok;
  logic [31:0] m_addr = '0, m_word;
  bit e_we = 0, e_done = 0, e_busy = 0;
  logic [31:0] e_addr = '0, e_data = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_rem = 0; m_cnt = 0; m_err = 0; m_addr = '0;
      e_we = 0; e_done = 0; e_busy = 0;
    end else begin
      e_we = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_err = 0; m_cnt = 0;
          m_addr = base_addr & 32'hFFFF_FFFC;
          m_rem = int'(count);
          m_phase = (count == 16'd0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          ref_word(cur_word(), m_ok, m_word);
          if (m_ok) begin
            e_we = 1; e_addr = m_addr; e_data = m_word;
            m_addr = m_addr + 32'd4;
            m_rem--;
            if (m_rem == 0) m_phase = 2;
          end else begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end else begin
        m_phase = 0;
      end
      e_done = (m_phase == 2);
      e_busy = (m_phase == 1);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("imem_we", 32'(imem_we), 32'(e_we));
      if (e_we) begin
        chk("imem_addr", imem_addr, e_addr);
        chk("imem_wdata", imem_wdata, e_data);
      end
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("in_ready", 32'(in_ready), 32'(e_busy));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (imem_we) wlog.push_back({imem_addr, imem_wdata});
    end
  end

  task automatic burst(input logic [31:0] base, input int cnt, input int vld_pct, input bit poke);
    bit seen = 0;
    wlog.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; count = 16'(cnt);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (in_ready && $urandom_range(99) < vld_pct) begin
        in_valid = 1'b1;
        if (pend.size() != 0) drive_word(pend.pop_front());
        else drive_word(rnd_word());
      end else begin
        in_valid = 1'b0;
      end
      if (poke && in_ready) begin
        start = ($urandom_range(3) == 0);
        base_addr = $urandom;
        count = 16'($urandom_range(1, 9));
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (!seen) chk("burst_done_timeout", 32'(seen), 32'd1);
    pend.delete();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_we"}, 32'(imem_we), 0);
    chk({nm, "_addr"}, imem_addr, 0);
    chk({nm, "_wdata"}, imem_wdata, 0);
    chk({nm, "_ready"}, 32'(in_ready), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_errcnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Two-word burst: R add then I addi.
    pend.push_back(mk(FMT_R, 6'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0));
    pend.push_back(mk(FMT_I, 6'h08, 5'd1, 5'd1, 5'd0, 6'd0, 16'd5, 26'd0));
    burst(32'h100, 2, 100, 0);
    chk("t1_nwrites", 32'(wlog.size()), 2);
    chk("t1_w0", wlog[0][31:0], 32'h0022_1820);
    chk("t1_a0", wlog[0][63:32], 32'h100);
    chk("t1_w1", wlog[1][31:0], 32'h2021_0005);
    chk("t1_a1", wlog[1][63:32], 32'h104);

    // Empty burst.
    burst(32'h200, 0, 100, 0);
    chk("t2_nwrites", 32'(wlog.size()), 0);

    // Rejected R word followed by a legal J word.
    pend.push_back(mk(FMT_R, 6'h08, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0));
    pend.push_back(mk(FMT_J, 6'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40));
    burst(32'h303, 1, 100, 0);
    chk("t3_err", 32'(err), 1);
    chk("t3_errcnt", 32'(err_cnt), 1);
    chk("t3_nwrites", 32'(wlog.size()), 1);
    chk("t3_w0", wlog[0][31:0], 32'h0800_0040);
    chk("t3_a0", wlog[0][63:32], 32'h300);

    // Address wrap.
    pend.push_back(mk(FMT_R, 6'd0, 5'd4, 5'd5, 5'd6, 6'h21, 16'd0, 26'd0));
    pend.push_back(mk(FMT_J, 6'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h123));
    burst(32'hFFFF_FFFC, 2, 100, 0);
    chk("t4_a0", wlog[0][63:32], 32'hFFFF_FFFC);
    chk("t4_a1", wlog[1][63:32], 32'h0);

    // Irregular valid with ignored start pulses.
    for (int i = 0; i < 3; i++)
      pend.push_back(mk(FMT_I, 6'h23, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 7), 26'd0));
    burst(32'h400, 3, 40, 1);
    chk("t5_nwrites", 32'(wlog.size()), 3);
    for (int i = 0; i < 3; i++) chk("t5_addr", wlog[i][63:32], 32'h400 + 32'(4 * i));

    // Reset after the first of three words, with a second word on the bus.
    @(negedge clk);
    start = 1'b1; base_addr = 32'h500; count = 16'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    drive_word(mk(FMT_R, 6'd0, 5'd7, 5'd8, 5'd9, 6'h22, 16'd0, 26'd0));
    @(negedge clk);
    drive_word(mk(FMT_R, 6'd0, 5'd1, 5'd1, 5'd1, 6'h24, 16'd0, 26'd0));
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", 32'(done), 0);
    pend.push_back(mk(FMT_J, 6'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF));
    pend.push_back(mk(FMT_I, 6'h0F, 5'd0, 5'd2, 5'd0, 6'd0, 16'hBEEF, 26'd0));
    burst(32'h600, 2, 100, 0);
    chk("t6_nwrites", 32'(wlog.size()), 2);
    chk("t6_w0", wlog[0][31:0], 32'h0BFF_FFFF);
    chk("t6_w1", wlog[1][31:0], 32'h3C02_BEEF);

    // Saturating reject counter, then cleared by the next start.
    for (int i = 0; i < 260; i++)
      pend.push_back(mk(FMT_ILLEGAL, 6'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0));
    pend.push_back(mk(FMT_J, 6'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd1));
    burst(32'h700, 1, 100, 0);
    chk("t7_errcnt_sat", 32'(err_cnt), 255);
    chk("t7_err", 32'(err), 1);
    chk("t7_nwrites", 32'(wlog.size()), 1);
    pend.push_back(mk(FMT_R, 6'd0, 5'd2, 5'd2, 5'd2, 6'h20, 16'd0, 26'd0));
    burst(32'h800, 1, 100, 0);
    chk("t7_err_clr", 32'(err), 0);
    chk("t7_errcnt_clr", 32'(err_cnt), 0);

    for (int b = 0; b < 25; b++)
      burst($urandom, int'($urandom_range(0, 6)), int'($urandom_range(30, 100)),
            bit'($urandom_range(1)));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of instruction-memory byte address.
REQ-002 SHALL have parameter CNT_W, default 16, width of word-count input.
REQ-003 Ports (clock and reset first):
  clk  input  1  single clock, all state on rising edge.
  rst_n  input  1  reset, asynchronous, active-low.
  start  input  1  one-cycle pulse; begins a load burst.
  base_addr  input  ADDR_W  first byte address of the burst; bits [1:0] ignored.
  count  input  CNT_W  number of valid words to write in the burst.
  in_valid  input  1  instruction fields present.
  in_ready  output  1  encoder accepts fields this cycle.
  fmt  input  INSN_FMT  R, I, J or ILLEGAL format selector.
  op  input  OPECODE  6-bit opcode.
  rs, rt, rd, shamt  input  5 each  register/shift fields.
  funct  input  FUNCT  6-bit function field.
  imm  input  16  I-format immediate.
  target  input  26  J-format target.
  imem_we  output  1  instruction-memory write enable.
  imem_addr  output  ADDR_W  write byte address, word-aligned.
  imem_wdata  output  32  encoded instruction word.
  busy  output  1  high in RUN.
  done  output  1  one-cycle pulse at burst end.
  err  output  1  sticky illegal-field flag.
  err_cnt  output  8  rejected-word count, saturating.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 IDLE: in_ready=0; start -> RUN when count!=0, -> DONE when count==0; start clears err and err_cnt, loads address {base_addr[ADDR_W-1:2],2'b00} and remaining=count.
REQ-006 RUN: in_ready=1; a transfer occurs when in_valid & in_ready.
REQ-007 Encoding: R = {6'b0,rs,rt,rd,shamt,funct}; I = {op,rs,rt,imm}; J = {op,target}.
REQ-008 Legality: R requires op==0; I requires op not 0, 2 or 3; J requires op 2 or 3; fmt ILLEGAL always illegal.
REQ-009 Legal transfer: imem_we=1, imem_addr=current address, imem_wdata=encoded word on the cycle after the transfer (registered, latency 1); address += 4, remaining -= 1.
REQ-010 Illegal transfer: word consumed, no write, address and remaining unchanged, err set, err_cnt += 1 saturating at 255.
REQ-011 Legal transfer with remaining==1: state -> DONE; in_ready drops the following cycle.
REQ-012 DONE: done=1 for exactly one cycle, then -> IDLE; final write (REQ-009) coincides with done.
REQ-013 Address wraps modulo 2^ADDR_W with no error.
REQ-014 start in RUN or DONE SHALL be ignored.
REQ-015 imem_we SHALL be 0 on every cycle not following a legal transfer.
REQ-016 busy = (state==RUN); err/err_cnt hold until next accepted start or reset.

Reset
REQ-017 rst_n low SHALL immediately force state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_cnt=0, remaining=0.
REQ-018 Reset mid-burst SHALL abort it without a done pulse; a transfer registered in the reset cycle SHALL not be written.

Structure
REQ-019 INSN_FMT enum and opcode constants OP_RTYPE=0, OP_J=2, OP_JAL=3 SHALL live in lib_cpu beside the existing OPECODE and FUNCT types.
REQ-020 Field packing and legality check SHALL be one combinational sub-module insn_pack (fields in -> word, legal out); FSM, counters, and output registers stay in instr_encoder.

Verification
REQ-021 start, base_addr=0x100, count=2; R add (rs=1,rt=2,rd=3,funct=0x20) then I addi (op=0x08,rs=1,rt=1,imm=5) -> writes 0x00221820 @0x100, 0x20210005 @0x104; done with second write.
REQ-022 count=0 start -> done next cycle, no imem_we, in_ready never high.
REQ-023 count=1; fmt=R with op=0x08, then J op=2 target=0x40 -> first rejected (err=1, err_cnt=1, no write), then 0x08000040 @base; done.
REQ-024 base_addr=0xFFFF_FFFC, count=2, two legal words -> writes @0xFFFF_FFFC and @0x0000_0000.
REQ-025 in_valid toggled irregularly, count=3 -> exactly 3 writes at consecutive addresses; start pulsed during RUN ignored.
REQ-026 rst_n asserted after 1 of 3 words -> all outputs 0 asynchronously, no done; new start afterwards completes normally.
